// File: rtl/ps2_host_tx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_pkg
//   Shared definitions for the PS/2 host transmitter and its line filter:
//   transmitter state encoding, default timing constants, timer width,
//   common PS/2 command/response codes and the frame parity helper.
// ---------------------------------------------------------------------------
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE,
      ST_DONE,
      ST_ERR
   } tx_state_t;

   // Defaults for a 50 MHz system clock
   localparam int unsigned DEF_INHIBIT_CYCLES = 5000;    // 100 us
   localparam int unsigned DEF_START_TIMEOUT  = 750000;  // 15 ms
   localparam int unsigned DEF_XFER_TIMEOUT   = 100000;  // 2 ms
   localparam int unsigned DEF_FILTER_LEN     = 8;

   localparam int unsigned TIMER_W = 20;

   // Index of the parity bit in the {parity, data} frame
   localparam logic [3:0] PARITY_IDX = 4'd8;

   localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
   localparam logic [7:0] CMD_RESET            = 8'hFF;
   localparam logic [7:0] RSP_ACK              = 8'hFA;

   // PS/2 frames use odd parity: data bits plus parity hold an odd count of 1s
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
//   Command-side handshake between a requester and the PS/2 host transmitter.
//     data  [7:0]  command byte, sampled when send && !busy
//     send         start strobe, ignored while busy
//     busy         transfer in progress
//     done         one-cycle pulse: byte sent and acked
//     err          one-cycle pulse: timeout or missing ack
//   master = requester, slave = transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;
   logic [7:0] data;
   logic       send;
   logic       busy;
   logic       done;
   logic       err;

   modport master (output data, send, input busy, done, err);
   modport slave  (input data, send, output busy, done, err);
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
//   Conditions one raw, asynchronous PS/2 line: 2-flop synchroniser followed
//   by a stability filter that accepts a new level only after it has been
//   seen for FILTER_LEN consecutive cycles. fall_o strobes for one cycle in
//   the same cycle line_o drops from 1 to 0.
//   Ports: clk, rst (async, active-high), line_in (raw), line_o (filtered),
//          fall_o (1->0 strobe).
// ---------------------------------------------------------------------------
module ps2_line_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_o,
   output logic fall_o
);

   localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       sync_q, sync_d;
   logic             line_q, line_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fall_q, fall_d;

   always_comb begin
      sync_d = {sync_q[0], line_in};
      line_d = line_q;
      cnt_d  = '0;
      fall_d = 1'b0;
      if (sync_q[1] != line_q) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            line_d = sync_q[1];
            fall_d = line_q;   // levels differ, so old level 1 means a fall
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser and filtered level reset to the idle-bus level (high) so
   // that leaving reset never produces a spurious fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         line_q <= 1'b1;
         cnt_q  <= '0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         line_q <= line_d;
         cnt_q  <= cnt_d;
         fall_q <= fall_d;
      end
   end

   assign line_o = line_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte to the attached
//   device: clock inhibit, request-to-send, bits shifted out on device clock
//   falls, odd parity, stop, ack check, start/transfer timeouts.
//   Ports:
//     clk, rst            system clock, async active-high reset
//     host (slave)        data/send in, busy/done/err out
//     ps2c_in, ps2d_in    raw PS/2 clock/data lines (asynchronous)
//     ps2c_low, ps2d_low  open-collector enables: 1 = pull line low
// ---------------------------------------------------------------------------
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
   parameter int unsigned XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
   parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  host,
   input  logic          ps2c_in,
   input  logic          ps2d_in,
   output logic          ps2c_low,
   output logic          ps2d_low
);

   tx_state_t          state_q, state_d;
   logic [8:0]         frame_q, frame_d;     // {parity, data}, shifted LSB-first
   logic [3:0]         bit_idx_q, bit_idx_d;
   logic [TIMER_W-1:0] timer_q, timer_d;

   logic c_filt, c_fall;
   logic d_filt, d_fall_unused;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2c_in),
      .line_o  (c_filt),
      .fall_o  (c_fall)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2d_in),
      .line_o  (d_filt),
      .fall_o  (d_fall_unused)
   );

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_idx_d = bit_idx_q;
      timer_d   = timer_q;
      ps2c_low  = 1'b0;
      ps2d_low  = 1'b0;
      host.busy = 1'b0;
      host.done = 1'b0;
      host.err  = 1'b0;

      // One down-counter serves every phase; each phase reloads it on entry
      if (timer_q != '0) begin
         timer_d = timer_q - TIMER_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (host.send) begin
               frame_d = {odd_parity(host.data), host.data};
               timer_d = TIMER_W'(INHIBIT_CYCLES - 1);
               state_d = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            host.busy = 1'b1;
            ps2c_low  = 1'b1;
            if (timer_q == '0) begin
               ps2d_low = 1'b1;   // start bit goes out in the last inhibit cycle
               timer_d  = TIMER_W'(START_TIMEOUT - 1);
               state_d  = ST_RTS;
            end
         end

         ST_RTS: begin
            host.busy = 1'b1;
            ps2d_low  = 1'b1;
            if (c_fall) begin
               ps2d_low  = ~frame_q[0];
               bit_idx_d = '0;
               timer_d   = TIMER_W'(XFER_TIMEOUT - 1);
               state_d   = ST_SHIFT;
            end else if (timer_q == '0) begin
               state_d = ST_ERR;
            end
         end

         // frame_q[0] always holds the bit on the wire; on a fall the next
         // bit is presented in the same cycle via the shifted value.
         ST_SHIFT: begin
            host.busy = 1'b1;
            ps2d_low  = ~frame_q[0];
            if (c_fall) begin
               bit_idx_d = bit_idx_q + 4'd1;
               frame_d   = {1'b1, frame_q[8:1]};
               if (bit_idx_q == PARITY_IDX) begin
                  ps2d_low = 1'b0;   // stop bit: release the data line
                  state_d  = ST_ACK;
               end else begin
                  ps2d_low = ~frame_q[1];
               end
            end else if (timer_q == '0) begin
               state_d = ST_ERR;
            end
         end

         ST_ACK: begin
            host.busy = 1'b1;
            if (c_fall) begin
               state_d = d_filt ? ST_ERR : ST_WAIT_IDLE;
            end else if (timer_q == '0) begin
               state_d = ST_ERR;
            end
         end

         ST_WAIT_IDLE: begin
            host.busy = 1'b1;
            if (c_filt && d_filt) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            host.done = 1'b1;
            state_d   = ST_IDLE;
         end

         ST_ERR: begin
            host.err = 1'b1;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         bit_idx_q <= '0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         bit_idx_q <= bit_idx_d;
         timer_q   <= timer_d;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//   Bench for ps2_host_tx with short timing parameters. A behavioural PS/2
//   device answers the host's request-to-send, clocks the frame in, and
//   optionally acks. Expected frames and outcomes are queued when a command
//   is issued and consumed when the DUT produces them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int unsigned INH   = 50;
   localparam int unsigned START = 2000;
   localparam int unsigned XFER  = 4000;
   localparam int unsigned FLT   = 4;
   localparam int unsigned H     = 20;   // device clock half period, in clk cycles

   localparam int unsigned M_ACK    = 0;
   localparam int unsigned M_NOACK  = 1;
   localparam int unsigned M_SILENT = 2;

   typedef struct {
      logic [7:0]  data;
      int unsigned mode;
      bit          glitch;
      bit          exp_done;   // 1 = done pulse expected, 0 = err pulse expected
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic ps2c_in, ps2d_in;
   logic ps2c_low, ps2d_low;
   logic dev_c, dev_d;

   ps2_host_tx_if host_if ();

   // Open-collector bus: either side may only pull low
   assign ps2c_in = ~ps2c_low & dev_c;
   assign ps2d_in = ~ps2d_low & dev_d;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .START_TIMEOUT  (START),
      .XFER_TIMEOUT   (XFER),
      .FILTER_LEN     (FLT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .host     (host_if),
      .ps2c_in  (ps2c_in),
      .ps2d_in  (ps2d_in),
      .ps2c_low (ps2c_low),
      .ps2d_low (ps2d_low)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   bit          exp_res_q[$];
   logic [7:0]  exp_frame_q[$];

   int unsigned inh_len = 0;
   int unsigned inh_cnt = 0;
   logic        inh_first_d, inh_last_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Outcome scoreboard and inhibit-phase monitor
   always @(negedge clk) begin
      bit e;
      if (rst) begin
         inh_len = 0;
      end else begin
         if (host_if.done || host_if.err) begin
            check("done_err_exclusive", {31'b0, host_if.done & host_if.err}, 0);
            if (exp_res_q.size() == 0) begin
               check("unexpected_pulse", {30'b0, host_if.done, host_if.err}, 0);
            end else begin
               e = exp_res_q.pop_front();
               check("outcome_done_err", {30'b0, host_if.done, host_if.err}, e ? 2 : 1);
            end
         end
         if (ps2c_low) begin
            if (inh_len == 0) inh_first_d = ps2d_low;
            inh_last_d = ps2d_low;
            inh_len++;
         end else if (inh_len != 0) begin
            check("inhibit_len", inh_len, INH);
            check("start_bit_last_cycle", {30'b0, inh_first_d, inh_last_d}, 2'b01);
            inh_cnt++;
            inh_len = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_send(input logic [7:0] b);
      host_if.data = b;
      host_if.send = 1'b1;
      @(negedge clk);
      host_if.send = 1'b0;
      check("busy_after_send", {31'b0, host_if.busy}, 1);
   endtask

   // Device side: wait for RTS, clock n_pulses, sample on rising clock,
   // drive ack before pulse 11 when ack_ok.
   task automatic dev_frame(input int unsigned n_pulses, input bit ack_ok, input bit glitch,
                            output logic [9:0] bits, output bit rts_seen);
      int unsigned t;
      bits     = '1;
      rts_seen = 1'b0;
      t        = 0;
      while (ps2c_in !== 1'b0 && t < 500) begin @(negedge clk); t++; end
      while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) return;
      rts_seen = 1'b1;
      repeat (H) @(negedge clk);
      for (int i = 0; i < 11 && i < int'(n_pulses); i++) begin
         if (i == 10 && ack_ok) begin
            dev_d = 1'b0;
            repeat (H/2) @(negedge clk);
         end
         dev_c = 1'b0;
         repeat (H) @(negedge clk);
         dev_c = 1'b1;
         if (i < 10) bits[i] = ps2d_in;
         if (glitch && i == 4) begin
            repeat (H/2 - 1) @(negedge clk);
            dev_c = 1'b0;
            repeat (2) @(negedge clk);
            dev_c = 1'b1;
            repeat (H/2 - 1) @(negedge clk);
         end else begin
            repeat (H) @(negedge clk);
         end
      end
      dev_d = 1'b1;
   endtask

   task automatic check_frame(input logic [9:0] bits, input bit seen);
      logic [7:0] eb;
      check("rts_seen", {31'b0, seen}, 1);
      if (exp_frame_q.size() == 0) begin
         check("frame_expected", 0, 1);
      end else begin
         eb = exp_frame_q.pop_front();
         check("data_bits", {24'b0, bits[7:0]}, {24'b0, eb});
         check("parity_bit", {31'b0, bits[8]}, {31'b0, ~^eb});
         check("stop_bit", {31'b0, bits[9]}, 1);
      end
   endtask

   task automatic wait_results();
      int unsigned t = 0;
      while (exp_res_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
      check("outcome_arrived", exp_res_q.size(), 0);
      exp_res_q.delete();
   endtask

   task automatic run_txn(input vec_t v);
      logic [9:0]  bits;
      bit          seen;
      int unsigned n, t;
      exp_res_q.push_back(v.exp_done);
      if (v.mode != M_SILENT) exp_frame_q.push_back(v.data);
      do_send(v.data);
      if (v.mode == M_SILENT) begin
         t = 0;
         while (ps2c_low !== 1'b0 && t < 200) begin @(negedge clk); t++; end
         n = 0;
         while (host_if.err !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
         check("start_timeout_cycles", n, START);
         check("lines_at_err", {30'b0, ps2c_low, ps2d_low}, 0);
      end else begin
         dev_frame(11, v.mode == M_ACK, v.glitch, bits, seen);
         check_frame(bits, seen);
      end
      wait_results();
      check("idle_after_txn", {29'b0, host_if.busy, ps2c_low, ps2d_low}, 0);
      repeat (40) @(negedge clk);
   endtask

   vec_t        tbl[6];
   logic [9:0]  bits;
   bit          seen;
   int unsigned frames_before;
   logic [7:0]  rst_byte;

   initial begin
      tbl[0] = '{data: 8'hF4, mode: M_ACK,    glitch: 1'b0, exp_done: 1'b1};
      tbl[1] = '{data: 8'hFF, mode: M_ACK,    glitch: 1'b0, exp_done: 1'b1};
      tbl[2] = '{data: 8'h00, mode: M_SILENT, glitch: 1'b0, exp_done: 1'b0};
      tbl[3] = '{data: 8'hA5, mode: M_NOACK,  glitch: 1'b0, exp_done: 1'b0};
      tbl[4] = '{data: 8'h3C, mode: M_ACK,    glitch: 1'b1, exp_done: 1'b1};
      tbl[5] = '{data: 8'h81, mode: M_ACK,    glitch: 1'b0, exp_done: 1'b1};

      rst          = 1'b1;
      host_if.data = '0;
      host_if.send = 1'b0;
      dev_c        = 1'b1;
      dev_d        = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {27'b0, host_if.busy, host_if.done, host_if.err, ps2c_low, ps2d_low}, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_outputs",
            {27'b0, host_if.busy, host_if.done, host_if.err, ps2c_low, ps2d_low}, 0);

      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i]);
      end

      // Second send while busy must be dropped: exactly one frame on the bus
      frames_before = inh_cnt;
      exp_res_q.push_back(1'b1);
      exp_frame_q.push_back(8'h12);
      do_send(8'h12);
      repeat (5) @(negedge clk);
      host_if.data = 8'h34;
      host_if.send = 1'b1;
      @(negedge clk);
      host_if.send = 1'b0;
      dev_frame(11, 1'b1, 1'b0, bits, seen);
      check_frame(bits, seen);
      wait_results();
      repeat (300) @(negedge clk);
      check("single_frame_only", inh_cnt - frames_before, 1);
      check("idle_after_drop", {31'b0, host_if.busy}, 0);

      // Reset in the middle of the data bits releases both lines at once
      rst_byte = 8'h52;
      do_send(rst_byte);
      dev_frame(4, 1'b0, 1'b0, bits, seen);
      check("mid_frame_busy", {31'b0, host_if.busy}, 1);
      check("mid_frame_d3", {31'b0, ps2d_low}, {31'b0, ~rst_byte[3]});
      rst = 1'b1;
      #1;
      check("async_reset_release",
            {27'b0, host_if.busy, host_if.done, host_if.err, ps2c_low, ps2d_low}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      run_txn('{data: 8'hF4, mode: M_ACK, glitch: 1'b0, exp_done: 1'b1});

      check("queues_drained", exp_res_q.size() + exp_frame_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
